// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: one outstanding req/ready bus cycle,
// byte-enable/lane generation for stores and aligned, extended load data.
//
// state  | meaning
// IDLE   | evaluate MEM-stage op; launch aligned access or flag misalignment
// ACCESS | bus request held until ready or timeout
// DONE   | one non-stalled cycle so the pipeline advances
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_mem2reg,
    input  logic        i_mem_wmem,
    input  logic        i_mem_lsb,
    input  logic        i_mem_lsh,
    input  logic        i_mem_loadsignext,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_dmem,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic        o_load_valid,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;

    logic        access, is_byte, is_half, misaligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    // load attributes are latched at launch so extraction does not depend on
    // the MEM-stage inputs staying frozen
    logic        ld_pend, ld_byte, ld_half, ld_sext;
    logic [1:0]  ld_off;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext_c;

    assign access     = i_mem_mem2reg | i_mem_wmem;
    assign is_byte    = i_mem_lsb;
    assign is_half    = ~i_mem_lsb & i_mem_lsh;
    assign misaligned = (is_half & i_mem_addr[0]) |
                        (~is_byte & ~is_half & (i_mem_addr[1:0] != 2'b00));

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = i_mem_dmem;
        if (is_byte) begin
            be_c    = 4'b0001 << i_mem_addr[1:0];
            wdata_c = {4{i_mem_dmem[7:0]}};
        end else if (is_half) begin
            be_c    = 4'b0011 << {i_mem_addr[1], 1'b0};
            wdata_c = {2{i_mem_dmem[15:0]}};
        end
    end

    always_comb begin
        lane_b = i_bus_rdata[{ld_off, 3'b000} +: 8];
        lane_h = ld_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        if (ld_byte)
            ext_c = {{24{ld_sext & lane_b[7]}}, lane_b};
        else if (ld_half)
            ext_c = {{16{ld_sext & lane_h[15]}}, lane_h};
        else
            ext_c = i_bus_rdata;
    end

    assign o_stall = ((state == IDLE) & access & ~misaligned) | (state == ACCESS);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            to_cnt       <= '0;
            o_load_data  <= '0;
            o_load_valid <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            o_bus_req    <= 1'b0;
            o_bus_we     <= 1'b0;
            o_bus_addr   <= '0;
            o_bus_be     <= '0;
            o_bus_wdata  <= '0;
            ld_pend      <= 1'b0;
            ld_byte      <= 1'b0;
            ld_half      <= 1'b0;
            ld_sext      <= 1'b0;
            ld_off       <= '0;
        end else begin
            o_load_valid <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && misaligned) begin
                        o_misaligned <= 1'b1;
                        if (!i_mem_wmem)
                            o_load_data <= '0;
                    end else if (access) begin
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_mem_wmem;
                        o_bus_addr  <= {i_mem_addr[31:2], 2'b00};
                        o_bus_be    <= be_c;
                        o_bus_wdata <= wdata_c;
                        ld_pend     <= ~i_mem_wmem;
                        ld_byte     <= is_byte;
                        ld_half     <= is_half;
                        ld_sext     <= i_mem_loadsignext;
                        ld_off      <= i_mem_addr[1:0];
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (i_bus_ready) begin
                        o_bus_req <= 1'b0;
                        if (ld_pend) begin
                            o_load_data  <= ext_c;
                            o_load_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else if (TO_EN && to_cnt == TO_LAST) begin
                        o_bus_req <= 1'b0;
                        o_bus_err <= 1'b1;
                        if (ld_pend)
                            o_load_data <= '0;
                        state <= DONE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                DONE: begin
                    to_cnt <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: per-cycle expected trace built from the
// access rules, compared every cycle, plus literal checks of key results.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_mem_mem2reg, i_mem_wmem, i_mem_lsb, i_mem_lsh, i_mem_loadsignext;
    logic [31:0] i_mem_addr, i_mem_dmem;
    logic        o_stall, o_load_valid, o_misaligned, o_bus_err, o_bus_req, o_bus_we;
    logic [31:0] o_load_data, o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ready;
    logic [31:0] i_bus_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_mem_mem2reg(i_mem_mem2reg), .i_mem_wmem(i_mem_wmem),
        .i_mem_lsb(i_mem_lsb), .i_mem_lsh(i_mem_lsh),
        .i_mem_loadsignext(i_mem_loadsignext),
        .i_mem_addr(i_mem_addr), .i_mem_dmem(i_mem_dmem),
        .o_stall(o_stall), .o_load_data(o_load_data), .o_load_valid(o_load_valid),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
        .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata)
    );

    typedef struct {
        logic        stall, req, lv, mis, err, chk_bus, we;
        logic [31:0] addr, wdata, ld;
        logic [3:0]  be;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_ld = '0;
    int          stall_cnt, req_cnt;
    logic [3:0]  last_be;
    logic [31:0] last_wdata, last_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic stall, input logic req);
        exp_t e;
        e.stall = stall; e.req = req; e.lv = 1'b0; e.mis = 1'b0; e.err = 1'b0;
        e.chk_bus = 1'b0; e.we = 1'b0; e.addr = '0; e.wdata = '0; e.be = '0;
        e.ld = m_ld;
        return e;
    endfunction

    function automatic logic [3:0] m_be(input int sz, input logic [1:0] off);
        case (sz)
            0:       return 4'(1 << off);
            1:       return off[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input int sz, input logic [31:0] d);
        case (sz)
            0:       return d[7:0] * 32'h0101_0101;
            1:       return d[15:0] * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_ext(input int sz, input logic [1:0] off,
                                          input bit sx, input logic [31:0] rd);
        logic [31:0] v;
        case (sz)
            0: begin
                v = (rd >> (8 * off)) & 32'hFF;
                if (sx && v[7]) v = v | 32'hFFFF_FF00;
            end
            1: begin
                v = (rd >> (16 * off[1])) & 32'hFFFF;
                if (sx && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    initial begin : cmp
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", 32'(o_stall), 32'(e.stall));
                chk("bus_req", 32'(o_bus_req), 32'(e.req));
                chk("load_valid", 32'(o_load_valid), 32'(e.lv));
                chk("misaligned", 32'(o_misaligned), 32'(e.mis));
                chk("bus_err", 32'(o_bus_err), 32'(e.err));
                chk("load_data", o_load_data, e.ld);
                if (e.chk_bus) begin
                    chk("bus_we", 32'(o_bus_we), 32'(e.we));
                    chk("bus_addr", o_bus_addr, e.addr);
                    chk("bus_be", 32'(o_bus_be), 32'(e.be));
                    chk("bus_wdata", o_bus_wdata, e.wdata);
                end
            end
        end
    end

    task automatic tick();
        #1;
        if (o_stall) stall_cnt++;
        if (o_bus_req) begin
            req_cnt++;
            last_be    = o_bus_be;
            last_wdata = o_bus_wdata;
            last_addr  = o_bus_addr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit ld, input bit st, input bit lsb, input bit lsh,
                          input bit sx, input logic [31:0] addr, input logic [31:0] d);
        i_mem_mem2reg = ld; i_mem_wmem = st; i_mem_lsb = lsb; i_mem_lsh = lsh;
        i_mem_loadsignext = sx; i_mem_addr = addr; i_mem_dmem = d;
    endtask

    task automatic set_idle();
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic do_op(input bit ld, input bit st, input bit lsb, input bit lsh,
                         input bit sx, input logic [31:0] addr, input logic [31:0] d,
                         input logic [31:0] rd, input int waits);
        int         sz, n;
        bit         mis, is_load, tmo;
        logic [1:0] off;
        exp_t       e;
        off     = addr[1:0];
        sz      = lsb ? 0 : (lsh ? 1 : 2);
        mis     = (sz == 1 && addr[0]) || (sz == 2 && off != 2'b00);
        is_load = ld && !st;
        stall_cnt = 0; req_cnt = 0;
        set_in(ld, st, lsb, lsh, sx, addr, d);
        i_bus_ready = 1'b0; i_bus_rdata = $urandom;
        e = mk(!mis, 1'b0); q.push_back(e); tick();
        if (mis) begin
            set_idle();
            if (is_load) m_ld = '0;
            e = mk(1'b0, 1'b0); e.mis = 1'b1; q.push_back(e); tick();
            return;
        end
        tmo = (waits >= TO);
        n   = tmo ? TO : waits + 1;
        for (int k = 1; k <= n; k++) begin
            i_bus_ready = !tmo && (k == n);
            i_bus_rdata = i_bus_ready ? rd : $urandom;
            e = mk(1'b1, 1'b1); e.chk_bus = 1'b1; e.we = st;
            e.addr = {addr[31:2], 2'b00}; e.be = m_be(sz, off); e.wdata = m_wd(sz, d);
            q.push_back(e); tick();
        end
        set_idle();
        i_bus_ready = 1'b0; i_bus_rdata = $urandom;
        if (is_load) m_ld = tmo ? 32'h0 : m_ext(sz, off, sx, rd);
        e = mk(1'b0, 1'b0); e.lv = is_load && !tmo; e.err = tmo;
        q.push_back(e); tick();
    endtask

    initial begin : drv
        exp_t e;
        i_reset = 1'b1; set_idle(); i_bus_ready = 1'b0; i_bus_rdata = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            e = mk(1'b0, 1'b0); e.chk_bus = 1'b1; q.push_back(e); tick();
        end
        i_reset = 1'b0;
        e = mk(1'b0, 1'b0); e.chk_bus = 1'b1; q.push_back(e); tick();

        // word store, zero-wait
        do_op(0, 1, 0, 0, 0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
        chk("lit_word_st_stall", stall_cnt, 2);
        chk("lit_word_st_be", 32'(last_be), 32'hF);
        chk("lit_word_st_wdata", last_wdata, 32'hDEAD_BEEF);

        // byte loads, signed then unsigned
        do_op(1, 0, 1, 0, 1, 32'h203, 32'h0, 32'h8011_2233, 0);
        chk("lit_byte_ld_sx", o_load_data, 32'hFFFF_FF80);
        chk("lit_byte_ld_be", 32'(last_be), 32'h8);
        do_op(1, 0, 1, 0, 0, 32'h203, 32'h0, 32'h8011_2233, 0);
        chk("lit_byte_ld_zx", o_load_data, 32'h0000_0080);

        // half store with three wait cycles
        do_op(0, 1, 0, 1, 0, 32'h12, 32'h0000_ABCD, 32'h0, 3);
        chk("lit_half_st_be", 32'(last_be), 32'hC);
        chk("lit_half_st_wdata", last_wdata, 32'hABCD_ABCD);
        chk("lit_half_st_addr", last_addr, 32'h10);
        chk("lit_half_st_req", req_cnt, 4);
        chk("lit_half_st_stall", stall_cnt, 5);

        // misaligned half load clears load data, no bus cycle
        do_op(1, 0, 0, 1, 0, 32'h5, 32'h0, 32'h0, 0);
        chk("lit_mis_ld_data", o_load_data, 32'h0);
        chk("lit_mis_ld_req", req_cnt, 0);
        chk("lit_mis_ld_stall", stall_cnt, 0);

        do_op(1, 0, 0, 1, 1, 32'h22, 32'h0, 32'h8001_7FFF, 0);
        chk("lit_half_ld_sx", o_load_data, 32'hFFFF_8001);
        do_op(1, 0, 0, 0, 0, 32'h40, 32'h0, 32'h1234_5678, 1);
        chk("lit_word_ld", o_load_data, 32'h1234_5678);

        // load that times out
        do_op(1, 0, 0, 0, 0, 32'h80, 32'h0, 32'h0, 10);
        chk("lit_tmo_req", req_cnt, 4);
        chk("lit_tmo_data", o_load_data, 32'h0);

        do_op(1, 0, 0, 1, 0, 32'h2, 32'h0, 32'h7777_1111, 0);
        // load+store together is a store; lsb beats lsh
        do_op(1, 1, 1, 1, 0, 32'h1, 32'h0000_005A, 32'hFFFF_FFFF, 0);
        chk("lit_both_ld_kept", o_load_data, 32'h0000_7777);
        chk("lit_both_be", 32'(last_be), 32'h2);
        chk("lit_both_wdata", last_wdata, 32'h5A5A_5A5A);
        do_op(0, 1, 0, 0, 0, 32'h2, 32'h1, 32'h0, 0);
        do_op(0, 1, 0, 0, 0, 32'h60, 32'h55AA_55AA, 32'h0, 7);

        // reset during the second ACCESS cycle
        set_in(1, 0, 0, 0, 0, 32'h300, 32'h0); i_bus_ready = 1'b0;
        e = mk(1'b1, 1'b0); q.push_back(e); tick();
        e = mk(1'b1, 1'b1); e.chk_bus = 1'b1; e.addr = 32'h300; e.be = 4'hF;
        q.push_back(e); tick();
        i_reset = 1'b1;
        q.push_back(e); tick();
        i_reset = 1'b0; set_idle(); m_ld = '0;
        e = mk(1'b0, 1'b0); e.chk_bus = 1'b1; q.push_back(e); tick();
        do_op(1, 0, 0, 0, 0, 32'h44, 32'h0, 32'hCAFE_F00D, 0);
        chk("lit_post_rst_ld", o_load_data, 32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the MEM-stage data-memory access for the 5-stage core.
- Consumes the control and data outputs of the EXE/MEM pipeline register (mem2reg, wmem, lsb, lsh, loadsignext, address, store data).
- Drives a single-outstanding req/ready data bus, generating byte enables and store-lane replication, and produces aligned, sign/zero-extended load data.
- Holds the pipeline via o_stall until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in ACCESS waiting for i_bus_ready before abort; 0 disables timeout
TO_W, 8, width of timeout counter (must hold TIMEOUT_CYCLES)

Ports:
i_clk  input  1  clock, all state on rising edge
i_reset  input  1  synchronous active-high reset
i_mem_mem2reg  input  1  load in MEM stage
i_mem_wmem  input  1  store in MEM stage
i_mem_lsb  input  1  byte access
i_mem_lsh  input  1  halfword access (lsb has priority if both set)
i_mem_loadsignext  input  1  1=sign-extend load, 0=zero-extend
i_mem_addr  input  32  byte address (ALU result)
i_mem_dmem  input  32  store data (rs2)
o_stall  output  1  hold IF..MEM pipeline registers
o_load_data  output  32  extended load result (registered)
o_load_valid  output  1  1-cycle pulse: o_load_data updated
o_misaligned  output  1  1-cycle pulse: misaligned access suppressed
o_bus_err  output  1  1-cycle pulse: bus timeout
o_bus_req  output  1  bus request
o_bus_we  output  1  1=write
o_bus_addr  output  32  word address ({i_mem_addr[31:2],2'b00})
o_bus_be  output  4  byte enables
o_bus_wdata  output  32  lane-replicated store data
i_bus_ready  input  1  slave accepts/completes access this cycle
i_bus_rdata  input  32  read data, valid when i_bus_ready=1

Behaviour:
- Reset (i_reset=1 at edge): state=IDLE, timeout counter=0. All registered outputs are 0: o_load_data, o_load_valid, o_misaligned, o_bus_err, o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata. Reset mid-ACCESS drops o_bus_req at that edge; the transaction is abandoned.
- access = i_mem_mem2reg | i_mem_wmem. If both are set, the access is a store (o_bus_we=1) and no load result is produced.
- Size: lsb → byte; else lsh → half; else word.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If access and aligned: register bus outputs, set o_bus_req=1, go to ACCESS.
  - If access and misaligned: pulse o_misaligned, issue no bus cycle, stay in IDLE.
  - o_stall (combinational) = (IDLE & access & aligned) | ACCESS.
- ACCESS:
  - o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata held stable.
  - If i_bus_ready=1: drop req. For a load, capture the extended rdata into o_load_data and pulse o_load_valid. Go to DONE.
  - Else increment the counter. When counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): drop req, pulse o_bus_err, set o_load_data=0 for a load, go to DONE.
- DONE: o_stall=0 for exactly one cycle so the pipeline advances. Clear the counter. Go to IDLE, which evaluates the next instruction.
- Zero-wait slave: a memory op occupies MEM for 3 cycles (2 stall cycles). Each additional wait cycle adds one.
- Byte enables, with off=addr[1:0]:
  - byte: 4'b0001<<off
  - half: 4'b0011<<{off[1],1'b0}
  - word: 4'b1111
- Store data:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- Load extract:
  - byte: lane rdata[8*off+:8]
  - half: rdata[16*off[1]+:16]
  - extend using bit 7 or 15 when loadsignext=1, else zero-fill.
- o_load_data holds its value until the next completed load, misaligned load (→0), or reset.
- Exactly one bus transaction is outstanding; req is never asserted in IDLE or DONE.

Test Plan:
- Word store, addr=0x100, d=0xDEADBEEF, ready on first ACCESS cycle → req/we=1, be=4'hF, wdata=0xDEADBEEF, o_stall high 2 cycles, DONE 1 cycle.
- Byte load signext=1, addr=0x203, rdata=0x80112233 → be=4'b1000, o_load_data=0xFFFFFF80, o_load_valid pulse. Repeat with signext=0 → 0x00000080.
- Half store, addr=0x12, d=0x0000ABCD, ready after 3 wait cycles → be=4'b1100, wdata=0xABCDABCD, req held with stable addr 0x10 for 4 cycles, stall 5 cycles.
- Half load at addr=0x5 → o_misaligned pulse, no o_bus_req, o_stall stays 0, o_load_data=0.
- TIMEOUT_CYCLES=4, word load, ready never asserted → req for 4 cycles, o_bus_err pulse, o_load_data=0, DONE, then IDLE.
- i_reset asserted during the 2nd ACCESS cycle → next edge o_bus_req=0, o_stall=0, all outputs 0, state IDLE. A back-to-back load after release completes normally.
